// File: rtl/reg_writeback.sv
// reg_writeback: merges ALU and load results into a small FIFO of pending
// register-file writes and drains one entry per cycle into a registered write
// port. Writes to r0 are handshaken but dropped. A hazard query reports
// whether a register still has a write in flight.
module reg_writeback #(
    parameter int DEPTH = 4
) (
    input  logic        CLOCK_50,
    input  logic        reset,
    input  logic        alu_valid,
    input  logic [2:0]  alu_wa,
    input  logic [31:0] alu_wd,
    output logic        alu_ready,
    input  logic        mem_valid,
    input  logic [2:0]  mem_wa,
    input  logic [31:0] mem_wd,
    output logic        mem_ready,
    output logic        write_enable,
    output logic [2:0]  WA,
    output logic [31:0] WD,
    input  logic [2:0]  qa,
    output logic        q_hit,
    output logic [3:0]  count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW-1:0] LAST_IDX = PW'(DEPTH - 1);
    localparam logic [3:0] DEPTH_M1 = 4'(DEPTH - 1);
    localparam logic [3:0] DEPTH_M2 = 4'(DEPTH - 2);

    logic [2:0]       entry_wa_q [DEPTH];
    logic [2:0]       entry_wa_d [DEPTH];
    logic [31:0]      entry_wd_q [DEPTH];
    logic [31:0]      entry_wd_d [DEPTH];
    logic [DEPTH-1:0] valid_q;
    logic [DEPTH-1:0] valid_d;
    logic [PW-1:0]    wr_ptr_q;
    logic [PW-1:0]    wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q;
    logic [PW-1:0]    rd_ptr_d;
    logic [3:0]       count_q;
    logic [3:0]       count_d;
    logic             write_enable_q;
    logic             write_enable_d;
    logic [2:0]       wa_q;
    logic [2:0]       wa_d;
    logic [31:0]      wd_q;
    logic [31:0]      wd_d;

    logic             mem_enq;
    logic             alu_enq;
    logic             pop;
    logic [PW-1:0]    alu_slot;

    // Circular pointer advance that also works for non-power-of-two depths.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST_IDX) ? '0 : p + 1'b1;
    endfunction

    // Ready comes only from the registered count, so a pop in the same cycle
    // never opens extra room; the load port gets the last free slot first.
    always_comb begin
        mem_ready = 1'b0;
        alu_ready = 1'b0;
        if (!reset) begin
            mem_ready = (count_q <= DEPTH_M1);
            alu_ready = (count_q <= DEPTH_M2) ||
                        ((count_q == DEPTH_M1) && !mem_valid);
        end
    end

    // Handshakes to r0 complete but are not queued; the load goes in first.
    always_comb begin
        mem_enq  = mem_valid && mem_ready && (mem_wa != 3'd0);
        alu_enq  = alu_valid && alu_ready && (alu_wa != 3'd0);
        pop      = (count_q != 4'd0);
        alu_slot = mem_enq ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    end

    // Next-state: pop the head into the write stage, then append new entries.
    always_comb begin
        entry_wa_d     = entry_wa_q;
        entry_wd_d     = entry_wd_q;
        valid_d        = valid_q;
        wr_ptr_d       = wr_ptr_q;
        rd_ptr_d       = rd_ptr_q;
        write_enable_d = 1'b0;
        wa_d           = wa_q;
        wd_d           = wd_q;
        count_d        = count_q + {3'b000, mem_enq} + {3'b000, alu_enq}
                         - {3'b000, pop};

        if (pop) begin
            write_enable_d    = 1'b1;
            wa_d              = entry_wa_q[rd_ptr_q];
            wd_d              = entry_wd_q[rd_ptr_q];
            valid_d[rd_ptr_q] = 1'b0;
            rd_ptr_d          = ptr_inc(rd_ptr_q);
        end

        if (mem_enq) begin
            entry_wa_d[wr_ptr_q] = mem_wa;
            entry_wd_d[wr_ptr_q] = mem_wd;
            valid_d[wr_ptr_q]    = 1'b1;
        end

        if (alu_enq) begin
            entry_wa_d[alu_slot] = alu_wa;
            entry_wd_d[alu_slot] = alu_wd;
            valid_d[alu_slot]    = 1'b1;
        end

        if (alu_enq) begin
            wr_ptr_d = ptr_inc(alu_slot);
        end else if (mem_enq) begin
            wr_ptr_d = ptr_inc(wr_ptr_q);
        end
    end

    // State registers with synchronous reset that discards all pending writes.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                entry_wa_q[i] <= '0;
                entry_wd_q[i] <= '0;
            end
            valid_q        <= '0;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            count_q        <= '0;
            write_enable_q <= 1'b0;
            wa_q           <= '0;
            wd_q           <= '0;
        end else begin
            entry_wa_q     <= entry_wa_d;
            entry_wd_q     <= entry_wd_d;
            valid_q        <= valid_d;
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            count_q        <= count_d;
            write_enable_q <= write_enable_d;
            wa_q           <= wa_d;
            wd_q           <= wd_d;
        end
    end

    // Hazard lookup over queued entries and the write stage; r0 never hits.
    always_comb begin
        q_hit = 1'b0;
        if (!reset && (qa != 3'd0)) begin
            if (write_enable_q && (wa_q == qa)) begin
                q_hit = 1'b1;
            end
            for (int i = 0; i < DEPTH; i++) begin
                if (valid_q[i] && (entry_wa_q[i] == qa)) begin
                    q_hit = 1'b1;
                end
            end
        end
    end

    assign write_enable = write_enable_q;
    assign WA           = wa_q;
    assign WD           = wd_q;
    assign count        = count_q;

endmodule
